axi4_slave_mem: RTL and testbench

AXI4 responder backed by a word-addressed internal memory. It is the slave-side counterpart of the master driver that drives `axi_if`. It sits as the DUT or reference target on the far end of `axi_if` and accepts FIXED, INCR and WRAP bursts on independent write and read paths. It exists so the UVM AXI4 environment has a synthesizable, protocol-correct endpoint to exercise.

---
 rtl/my_pack.sv | 34 +++
 rtl/axi_if.sv | 62 ++++++
 rtl/axi_burst_addr_gen.sv | 28 ++
 rtl/axi4_slave_mem.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/my_pack.sv
// rtl/my_pack.sv - shared AXI4 enums and helpers for the slave memory
package my_pack;

  typedef enum logic [1:0] {
    FIXED    = 2'd0,
    INCR     = 2'd1,
    WRAP     = 2'd2,
    RESERVED = 2'd3
  } burst_type;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_type;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_if.sv
// rtl/axi_if.sv - AXI4 bus bundle with master and slave views
interface axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
  import my_pack::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_type             burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] mask;

  // WRAP keeps the upper bits of the aligned window and rolls the low bits
  always_comb begin
    incr  = ADDR_WIDTH'(1) << size;
    total = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    mask  = total - ADDR_WIDTH'(1);
    case (burst)
      INCR:    next_addr = addr + incr;
      WRAP:    next_addr = (addr & ~mask) | ((addr + incr) & mask);
      default: next_addr = addr;
    endcase
  end
endmodule

// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 responder backed by a word-addressed memory
module axi4_slave_mem
  import my_pack::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int MEM_DEPTH  = 256
) (
  input logic  aclk,
  input logic  areset,
  axi_if.slave s
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * STRB_W);
  localparam logic [2:0]            MAX_SIZE  = 3'(OFF_W);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return a >= MEM_BYTES;
  endfunction

  function automatic logic start_err(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size,
                                     input logic [7:0] len, input logic [1:0] burst);
    return out_of_range(a) || (size > MAX_SIZE) ||
           ((burst_type'(burst) == WRAP) && !wrap_len_ok(len)) ||
           (burst_type'(burst) == RESERVED);
  endfunction

  // ---------------- write path ----------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_nx;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  burst_type             w_burst;
  logic                  w_err, w_err_n;
  logic                  awready_q, wready_q, bvalid_q;
  logic                  awready_n, wready_n, bvalid_n;
  logic [ID_WIDTH-1:0]   bid_q, bid_n;
  logic [1:0]            bresp_q, bresp_n;
  logic                  aw_hs, w_hs, b_hs, w_last_beat, w_beat_err;

  assign s.awready   = awready_q;
  assign s.wready    = wready_q;
  assign s.bvalid    = bvalid_q;
  assign s.bid       = bid_q;
  assign s.bresp     = bresp_q;
  assign aw_hs       = s.awvalid && awready_q;
  assign w_hs        = s.wvalid && wready_q;
  assign b_hs        = bvalid_q && s.bready;
  assign w_last_beat = (w_cnt == w_len);
  // a beat that has walked off the end of memory is as bad as a bad start
  assign w_beat_err  = w_err || out_of_range(w_addr);

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr_gen (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_addr_nx)
  );

  // write FSM state, registered outputs and burst bookkeeping
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_size    <= '0;
      w_burst   <= FIXED;
      w_err     <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bid_q     <= bid_n;
      bresp_q   <= bresp_n;
      w_err     <= w_err_n;
      if (aw_hs) begin
        w_id    <= s.awid;
        w_addr  <= s.awaddr;
        w_len   <= s.awlen;
        w_size  <= s.awsize;
        w_burst <= burst_type'(s.awburst);
        w_cnt   <= '0;
      end else if (w_hs) begin
        w_addr  <= w_addr_nx;
        w_cnt   <= w_cnt + 8'd1;
      end
    end
  end

  // write FSM next state and sticky error update
  always_comb begin
    w_next  = w_state;
    w_err_n = w_err;
    case (w_state)
      W_IDLE: if (aw_hs) begin
        w_next  = W_DATA;
        w_err_n = start_err(s.awaddr, s.awsize, s.awlen, s.awburst);
      end
      W_DATA: if (w_hs) begin
        w_err_n = w_beat_err || (s.wlast != w_last_beat);
        if (w_last_beat) w_next = W_RESP;
      end
      W_RESP: if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // write channel outputs for the coming cycle
  always_comb begin
    awready_n = (w_next == W_IDLE);
    wready_n  = (w_next == W_DATA);
    bvalid_n  = (w_next == W_RESP);
    bid_n     = (w_next == W_RESP) ? w_id : '0;
    bresp_n   = (w_next == W_RESP) ? (w_err_n ? SLVERR : OKAY) : OKAY;
  end

  // byte-lane memory write; errored beats are dropped
  always_ff @(posedge aclk) begin
    if (!areset && w_hs && !w_beat_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s.wstrb[i]) mem[idx_of(w_addr)][8*i +: 8] <= s.wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx, load_addr;
  logic [7:0]            r_len, r_cnt, load_cnt, load_len;
  logic [2:0]            r_size;
  burst_type             r_burst;
  logic                  r_err, load_err, r_load;
  logic                  arready_q, rvalid_q, rlast_q;
  logic                  arready_n, rvalid_n, rlast_n;
  logic [ID_WIDTH-1:0]   rid_q, rid_n;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
  logic [1:0]            rresp_q, rresp_n;
  logic                  ar_hs, r_hs;

  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rid     = rid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rlast   = rlast_q;
  assign ar_hs     = s.arvalid && arready_q;
  assign r_hs      = rvalid_q && s.rready;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr_gen (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_addr_nx)
  );

  // read FSM state, registered outputs and burst bookkeeping
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= FIXED;
      r_err     <= 1'b0;
    end else begin
      r_state   <= r_next;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rlast_q   <= rlast_n;
      rid_q     <= rid_n;
      rdata_q   <= rdata_n;
      rresp_q   <= rresp_n;
      if (r_load) begin
        r_addr <= load_addr;
        r_cnt  <= load_cnt;
        r_err  <= load_err;
      end
      if (ar_hs) begin
        r_id    <= s.arid;
        r_len   <= s.arlen;
        r_size  <= s.arsize;
        r_burst <= burst_type'(s.arburst);
      end
    end
  end

  // read FSM next state
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // pick the beat to present next; a stalled beat simply holds
  always_comb begin
    r_load    = 1'b0;
    load_addr = r_addr_nx;
    load_cnt  = r_cnt + 8'd1;
    load_len  = r_len;
    load_err  = r_err;
    if (ar_hs) begin
      r_load    = 1'b1;
      load_addr = s.araddr;
      load_cnt  = '0;
      load_len  = s.arlen;
      load_err  = start_err(s.araddr, s.arsize, s.arlen, s.arburst);
    end else if (r_hs && !rlast_q) begin
      r_load    = 1'b1;
    end
    load_err  = load_err || out_of_range(load_addr);

    arready_n = (r_next == R_IDLE);
    rvalid_n  = (r_next == R_DATA);
    rid_n     = rid_q;
    rdata_n   = rdata_q;
    rresp_n   = rresp_q;
    rlast_n   = rlast_q;
    if (r_load) begin
      rid_n   = ar_hs ? s.arid : r_id;
      rdata_n = load_err ? '0 : mem[idx_of(load_addr)];
      rresp_n = load_err ? SLVERR : OKAY;
      rlast_n = (load_cnt == load_len);
    end else if (r_next != R_DATA) begin
      rid_n   = '0;
      rdata_n = '0;
      rresp_n = OKAY;
      rlast_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - directed self-checking bench for axi4_slave_mem
module tb_axi4_slave_mem;
  import my_pack::*;

  logic aclk = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2)) bus ();

  axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(2), .MEM_DEPTH(256)) dut (
    .aclk(aclk), .areset(areset), .s(bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    while (bus.awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n == 50) check("aw_timeout", bus.awready, 1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (bus.wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n == 50) check("w_timeout", bus.wready, 1);
    @(negedge aclk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic do_b(input string tag, input logic [1:0] id, input logic [1:0] resp);
    int n = 0;
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    check({tag, "_bvalid"}, bus.bvalid, 1);
    check({tag, "_bid"}, bus.bid, id);
    check({tag, "_bresp"}, bus.bresp, resp);
    @(negedge aclk);
    bus.bready = 1'b0;
  endtask

  task automatic do_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    while (bus.arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (n == 50) check("ar_timeout", bus.arready, 1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
  endtask

  task automatic do_r(input string tag, input logic [31:0] data, input logic [1:0] resp,
                      input logic last, input logic [1:0] id);
    int n = 0;
    bus.rready = 1'b1;
    while (bus.rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    check({tag, "_rvalid"}, bus.rvalid, 1);
    check({tag, "_rdata"}, bus.rdata, data);
    check({tag, "_rresp"}, bus.rresp, resp);
    check({tag, "_rlast"}, bus.rlast, last);
    check({tag, "_rid"}, bus.rid, id);
    @(negedge aclk);
    bus.rready = 1'b0;
  endtask

  logic [31:0] exp_q [4];

  initial begin
    areset = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_arready", bus.arready, 1);

    // single write then read back
    do_aw(2'd1, 32'h10, 8'd0, 3'd2, INCR);
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    do_b("single", 2'd1, OKAY);
    do_ar(2'd2, 32'h10, 8'd0, 3'd2, INCR);
    do_r("single", 32'hDEADBEEF, OKAY, 1'b1, 2'd2);

    // INCR burst of 4 words at 0x0
    do_aw(2'd0, 32'h0, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) do_w(32'(i + 1), 4'hF, i == 3);
    do_b("incr", 2'd0, OKAY);
    do_ar(2'd3, 32'h0, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) do_r($sformatf("incr%0d", i), 32'(i + 1), OKAY, i == 3, 2'd3);

    // WRAP burst: 0x08, 0x0C, 0x00, 0x04
    do_aw(2'd1, 32'h08, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) do_w(32'hA0 + 32'(i), 4'hF, i == 3);
    do_b("wrap", 2'd1, OKAY);
    exp_q[0] = 32'hA2; exp_q[1] = 32'hA3; exp_q[2] = 32'hA0; exp_q[3] = 32'hA1;
    do_ar(2'd0, 32'h0, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) do_r($sformatf("wrap_lin%0d", i), exp_q[i], OKAY, i == 3, 2'd0);
    do_ar(2'd1, 32'h08, 8'd3, 3'd2, WRAP);
    for (int i = 0; i < 4; i++) do_r($sformatf("wrap_rd%0d", i), 32'hA0 + 32'(i), OKAY, i == 3, 2'd1);

    // byte strobes
    do_aw(2'd2, 32'h20, 8'd0, 3'd2, INCR);
    do_w(32'hFFFFFFFF, 4'hF, 1'b1);
    do_b("strb_a", 2'd2, OKAY);
    do_aw(2'd2, 32'h20, 8'd0, 3'd2, INCR);
    do_w(32'h00000000, 4'h5, 1'b1);
    do_b("strb_b", 2'd2, OKAY);
    do_ar(2'd2, 32'h20, 8'd0, 3'd2, INCR);
    do_r("strb", 32'hFF00FF00, OKAY, 1'b1, 2'd2);

    // out-of-range start address
    do_aw(2'd3, 32'h400, 8'd1, 3'd2, INCR);
    do_w(32'h11111111, 4'hF, 1'b0);
    do_w(32'h22222222, 4'hF, 1'b1);
    do_b("oor", 2'd3, SLVERR);
    do_ar(2'd0, 32'h0, 8'd0, 3'd2, INCR);
    do_r("oor_mem", 32'hA2, OKAY, 1'b1, 2'd0);
    do_ar(2'd3, 32'h400, 8'd1, 3'd2, INCR);
    do_r("oor_r0", 32'h0, SLVERR, 1'b0, 2'd3);
    do_r("oor_r1", 32'h0, SLVERR, 1'b1, 2'd3);

    // illegal WRAP length
    do_aw(2'd1, 32'h40, 8'd2, 3'd2, WRAP);
    for (int i = 0; i < 3; i++) do_w(32'h33, 4'hF, i == 2);
    do_b("wrap_len", 2'd1, SLVERR);

    // early wlast
    do_aw(2'd0, 32'h30, 8'd1, 3'd2, INCR);
    do_w(32'h44, 4'hF, 1'b1);
    do_w(32'h45, 4'hF, 1'b1);
    do_b("early_last", 2'd0, SLVERR);

    // B back-pressure
    do_aw(2'd2, 32'h34, 8'd0, 3'd2, INCR);
    do_w(32'h12345678, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_bvalid%0d", i), bus.bvalid, 1);
      check($sformatf("bp_awready%0d", i), bus.awready, 0);
      @(negedge aclk);
    end
    do_b("bp", 2'd2, OKAY);
    check("bp_awready_after", bus.awready, 1);

    // R back-pressure with rready toggling
    do_ar(2'd1, 32'h0, 8'd3, 3'd2, INCR);
    for (int i = 0; i < 4; i++) begin
      bus.rready = 1'b0;
      @(negedge aclk);
      check($sformatf("stall_rdata%0d", i), bus.rdata, exp_q[i]);
      do_r($sformatf("stall%0d", i), exp_q[i], OKAY, i == 3, 2'd1);
    end

    // reset mid-burst on both paths
    do_aw(2'd3, 32'h50, 8'd3, 3'd2, INCR);
    do_w(32'h55, 4'hF, 1'b0);
    do_ar(2'd2, 32'h0, 8'd3, 3'd2, INCR);
    check("mid_rvalid_pre", bus.rvalid, 1);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_awready", bus.awready, 0);
    check("mid_wready", bus.wready, 0);
    check("mid_bvalid", bus.bvalid, 0);
    check("mid_arready", bus.arready, 0);
    check("mid_rvalid", bus.rvalid, 0);
    check("mid_rdata", bus.rdata, 0);
    check("mid_rlast", bus.rlast, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("rel_awready", bus.awready, 1);
    check("rel_arready", bus.arready, 1);
    check("rel_wready", bus.wready, 0);
    check("rel_rvalid", bus.rvalid, 0);
    do_ar(2'd0, 32'h10, 8'd0, 3'd2, INCR);
    do_r("retained", 32'hDEADBEEF, OKAY, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
